// File: rtl/seven_seg_pkg.sv
// Shared types and the active-low hex font for the seven-segment scanner.
// Segment order is {dp,g,f,e,d,c,b,a}; a 0 bit lights the segment.
package seven_seg_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [7:0] seg_t;

    localparam seg_t SEG_0 = 8'hC0;
    localparam seg_t SEG_1 = 8'hF9;
    localparam seg_t SEG_2 = 8'hA4;
    localparam seg_t SEG_3 = 8'hB0;
    localparam seg_t SEG_4 = 8'h99;
    localparam seg_t SEG_5 = 8'h92;
    localparam seg_t SEG_6 = 8'h82;
    localparam seg_t SEG_7 = 8'hF8;
    localparam seg_t SEG_8 = 8'h80;
    localparam seg_t SEG_9 = 8'h90;
    localparam seg_t SEG_A = 8'h88;
    localparam seg_t SEG_B = 8'h83;
    localparam seg_t SEG_C = 8'hC6;
    localparam seg_t SEG_D = 8'hA1;
    localparam seg_t SEG_E = 8'h86;
    localparam seg_t SEG_F = 8'h8E;

    localparam seg_t SEG_BLANK = 8'hFF;

    // Wide enough for the largest legal digit count; sliced by the user.
    localparam logic [7:0] AN_OFF = 8'hFF;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble decoder: hex font plus an active-high decimal-point request.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    seg_t font;

    always_comb begin
        font = SEG_BLANK;
        case (nib_i)
            4'h0: font = SEG_0;
            4'h1: font = SEG_1;
            4'h2: font = SEG_2;
            4'h3: font = SEG_3;
            4'h4: font = SEG_4;
            4'h5: font = SEG_5;
            4'h6: font = SEG_6;
            4'h7: font = SEG_7;
            4'h8: font = SEG_8;
            4'h9: font = SEG_9;
            4'hA: font = SEG_A;
            4'hB: font = SEG_B;
            4'hC: font = SEG_C;
            4'hD: font = SEG_D;
            4'hE: font = SEG_E;
            4'hF: font = SEG_F;
            default: font = SEG_BLANK;
        endcase
    end

    assign seg_o = {font[7] & ~dp_i, font[6:0]};

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver with pending/display
// double buffering so a new value only appears at a frame boundary.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    blank_lz_i,
    output logic [7:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int PW = ($clog2(REFRESH_DIV) > 0) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = ($clog2(NUM_DIGITS) > 0) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = AN_OFF[NUM_DIGITS-1:0];

    logic [PW-1:0]           pcnt_q, pcnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    seg_t                    seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_q, frame_d;

    logic                    pcnt_wrap;
    logic                    boundary;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    higher_zero;
    nibble_t                 cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    seg_t                    dec_seg;
    seg_t                    pattern;

    assign pcnt_wrap = (pcnt_q == PCNT_LAST);
    assign boundary  = pcnt_wrap && (idx_q == IDX_LAST);

    always_comb begin
        pcnt_d = pcnt_q;
        idx_d  = idx_q;
        if (en_i) begin
            if (pcnt_wrap) begin
                pcnt_d = '0;
                idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        lz_mask     = '0;
        higher_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            higher_zero = higher_zero && (disp_val_q[4*k +: 4] == 4'h0);
            if (k != 0) begin
                lz_mask[k] = blank_lz_i && higher_zero;
            end
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) == idx_q) begin
                cur_nib   = disp_val_q[4*k +: 4];
                cur_dp    = disp_dp_q[k];
                cur_blank = lz_mask[k];
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .nib_i (cur_nib),
        .dp_i  (cur_dp),
        .seg_o (dec_seg)
    );

    // A blanked digit keeps its anode and its decimal point.
    assign pattern = cur_blank ? {~cur_dp, 7'h7F} : dec_seg;

    always_comb begin
        seg_d   = SEG_BLANK;
        an_d    = AN_ALL_OFF;
        frame_d = en_i && boundary;
        if (en_i && (pcnt_q != '0)) begin
            seg_d = pattern;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                an_d[k] = (IW'(k) != idx_q);
            end
        end
    end

    always_comb begin
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        if (load_i) begin
            pend_val_d   = value_i;
            pend_dp_d    = dp_i;
            pend_valid_d = 1'b1;
        end
        // A load coinciding with the boundary bypasses the pending stage.
        if (en_i && boundary) begin
            pend_valid_d = 1'b0;
            if (load_i) begin
                disp_val_d = value_i;
                disp_dp_d  = dp_i;
            end else if (pend_valid_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q       <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            seg_q        <= SEG_BLANK;
            an_q         <= AN_ALL_OFF;
            frame_q      <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_q      <= frame_d;
        end
    end

    assign seg_o   = seg_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with NUM_DIGITS=4, REFRESH_DIV=4.
module tb_seven_seg_scanner;

    localparam int ND = 4;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en_i = 1'b1;
    logic          load_i = 1'b0;
    logic [15:0]   value_i = '0;
    logic [3:0]    dp_i = '0;
    logic          blank_lz_i = 1'b0;
    logic [7:0]    seg_o;
    logic [3:0]    an_o;
    logic          frame_o;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        string       name;
        logic [15:0] value;
        logic [3:0]  dp;
        logic        blank;
        logic [31:0] exp_seg;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs[6];

    seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en_i),
        .load_i     (load_i),
        .value_i    (value_i),
        .dp_i       (dp_i),
        .blank_lz_i (blank_lz_i),
        .seg_o      (seg_o),
        .an_o       (an_o),
        .frame_o    (frame_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] val, input logic [3:0] dp);
        value_i = val;
        dp_i    = dp;
        load_i  = 1'b1;
        @(negedge clk);
        load_i  = 1'b0;
    endtask

    // Advance at least one cycle, then stop on the cycle where frame_o is high.
    task automatic wait_frame(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_o && n < 64);
        chk({nm, "_frame_wait"}, {15'd0, frame_o}, 16'd1);
    endtask

    // Called on a frame_o cycle; checks the following 16 cycles of scan and
    // optionally drives loads at given steps (0 = none).
    task automatic check_frame(input string nm, input logic [31:0] exp_seg,
                               input int ls1, input logic [15:0] lv1,
                               input int ls2, input logic [15:0] lv2);
        logic [3:0]  an_exp;
        logic [15:0] e;
        exp_q.delete();
        for (int d = 0; d < ND; d++) begin
            an_exp = 4'hF;
            an_exp[d] = 1'b0;
            exp_q.push_back({8'h0F, 8'hFF});
            for (int p = 1; p < RD; p++) exp_q.push_back({4'h0, an_exp, exp_seg[d*8 +: 8]});
        end
        for (int step = 1; step <= ND * RD; step++) begin
            @(negedge clk);
            load_i = 1'b0;
            e = exp_q.pop_front();
            chk($sformatf("%s_s%0d", nm, step), {4'h0, an_o, seg_o}, e);
            chk($sformatf("%s_frame_s%0d", nm, step), {15'd0, frame_o}, {15'd0, step == ND * RD});
            if (step == ls1) begin value_i = lv1; load_i = 1'b1; end
            if (step == ls2) begin value_i = lv2; load_i = 1'b1; end
        end
        load_i = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"basic",   16'h1234, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        vecs[1] = '{"hex_dp",  16'hABF0, 4'b0001, 1'b0, {8'h88, 8'h83, 8'h8E, 8'h40}};
        vecs[2] = '{"lz_0050", 16'h0050, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h92, 8'hC0}};
        vecs[3] = '{"lz_0000", 16'h0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[4] = '{"lz_dp",   16'h0005, 4'b1000, 1'b1, {8'h7F, 8'hFF, 8'hFF, 8'h92}};
        vecs[5] = '{"lz_mid0", 16'h0C0D, 4'b0000, 1'b1, {8'hFF, 8'hC6, 8'hC0, 8'hA1}};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_seg", {8'h0, seg_o}, 16'h00FF);
        chk("rst_an", {12'h0, an_o}, 16'h000F);
        chk("rst_frame", {15'd0, frame_o}, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_dead", {4'h0, an_o, seg_o}, 16'h0FFF);
        chk("post_rst_frame", {15'd0, frame_o}, 16'd0);
        @(negedge clk);
        chk("post_rst_digit0", {4'h0, an_o, seg_o}, 16'h0EC0);
        wait_frame("init");

        // Table-driven frame checks
        foreach (vecs[i]) begin
            blank_lz_i = vecs[i].blank;
            do_load(vecs[i].value, vecs[i].dp);
            wait_frame(vecs[i].name);
            check_frame(vecs[i].name, vecs[i].exp_seg, 0, 16'h0, 0, 16'h0);
        end

        // Tear-free update, last-load-wins, boundary-edge load
        blank_lz_i = 1'b0;
        do_load(16'h1111, 4'b0000);
        wait_frame("tear");
        check_frame("tear_hold", {4{8'hF9}}, 3, 16'h2222, 8, 16'h3333);
        check_frame("tear_last", {4{8'hB0}}, 15, 16'h4444, 0, 16'h0);
        check_frame("bnd_load", {4{8'h99}}, 0, 16'h0, 0, 16'h0);

        // Enable freeze at idx=1, pcnt=2
        repeat (6) @(negedge clk);
        en_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("dis_out_%0d", i), {4'h0, an_o, seg_o}, 16'h0FFF);
            chk($sformatf("dis_frame_%0d", i), {15'd0, frame_o}, 16'd0);
        end
        en_i = 1'b1;
        @(negedge clk);
        chk("resume_digit1", {4'h0, an_o, seg_o}, 16'h0D99);
        chk("resume_frame_1", {15'd0, frame_o}, 16'd0);
        for (int n = 2; n <= 10; n++) begin
            @(negedge clk);
            chk($sformatf("resume_frame_%0d", n), {15'd0, frame_o}, {15'd0, n == 10});
        end

        // Reset mid-scan at idx=2, pcnt=3
        repeat (11) @(negedge clk);
        chk("pre_rst_digit2", {4'h0, an_o, seg_o}, 16'h0B99);
        rst = 1'b1;
        #1;
        chk("mid_rst_out", {4'h0, an_o, seg_o}, 16'h0FFF);
        chk("mid_rst_frame", {15'd0, frame_o}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_dead", {4'h0, an_o, seg_o}, 16'h0FFF);
        @(negedge clk);
        chk("mid_rst_digit0", {4'h0, an_o, seg_o}, 16'h0EC0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
